// File: rtl/sqrt_drv_pkg.sv
// Shared types and constants for the square-root sweep driver.
package sqrt_drv_pkg;

  localparam int unsigned OPER_W  = 8;
  localparam int unsigned ROOT_W  = 4;
  localparam int unsigned HOLDOFF = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StStart,
    StWait,
    StCheck,
    StNext,
    StDone
  } state_e;

endpackage

// File: rtl/sqrt_result_check.sv
// Combinational check that r is the integer square root of n: r*r <= n < (r+1)*(r+1).
module sqrt_result_check
  import sqrt_drv_pkg::*;
(
  input  logic [OPER_W-1:0] n,
  input  logic [ROOT_W-1:0] r,
  output logic              ok
);

  // One bit wider than the operand so (15+1)^2 = 256 does not wrap.
  logic [OPER_W:0] r_ext;
  logic [OPER_W:0] n_ext;
  logic [OPER_W:0] sq_lo;
  logic [OPER_W:0] sq_hi;

  always_comb begin
    r_ext = {{(OPER_W + 1 - ROOT_W){1'b0}}, r};
    n_ext = {1'b0, n};
    sq_lo = r_ext * r_ext;
    sq_hi = (r_ext + (OPER_W + 1)'(1)) * (r_ext + (OPER_W + 1)'(1));
    ok    = (sq_lo <= n_ext) && (sq_hi > n_ext);
  end

endmodule

// File: rtl/sqrt_sweep_driver.sv
// Sweeps DEPTH operands through the square-root unit and checks every result.
// Optional SQRT_TIMEOUT_EN bounds each wait for done to TIMEOUT cycles.
module sqrt_sweep_driver
  import sqrt_drv_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [OPER_W-1:0] mem_data,
  output logic              sq_start,
  output logic [OPER_W-1:0] sq_n,
  input  logic              sq_done,
  input  logic [ROOT_W-1:0] sq_root,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W:0]   err_count,
  output logic [OPER_W-1:0] fail_n
);

  localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ErrMax  = '1;

  state_e            state_q;
  logic [ROOT_W-1:0] root_q;
  logic [HOLD_W-1:0] hold_q;
  logic              ok;

`ifdef SQRT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q;
`endif

  sqrt_result_check u_check (
    .n  (sq_n),
    .r  (root_q),
    .ok (ok)
  );

  // mem_addr doubles as the sweep index so the address is valid in READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mem_addr  <= '0;
      sq_start  <= 1'b0;
      sq_n      <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      err_count <= '0;
      fail_n    <= '0;
      root_q    <= '0;
      hold_q    <= '0;
`ifdef SQRT_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      sq_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            err_count <= '0;
            fail_n    <= '0;
            mem_addr  <= '0;
            busy      <= 1'b1;
            state_q   <= StRead;
          end
        end
        StRead:  state_q <= StLatch;
        StLatch: begin
          sq_n     <= mem_data;
          sq_start <= 1'b1;
          state_q  <= StStart;
        end
        StStart: begin
          hold_q  <= '0;
`ifdef SQRT_TIMEOUT_EN
          to_q    <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
`ifdef SQRT_TIMEOUT_EN
          to_q <= to_q + TO_W'(1);
`endif
          // A stale done may linger for one cycle after start; ignore it.
          if (hold_q != HOLD_W'(HOLDOFF)) begin
            hold_q <= hold_q + HOLD_W'(1);
          end else if (sq_done) begin
            root_q  <= sq_root;
            state_q <= StCheck;
          end
`ifdef SQRT_TIMEOUT_EN
          if (!(hold_q == HOLD_W'(HOLDOFF) && sq_done) && to_q == TO_W'(TIMEOUT - 1)) begin
            if (err_count != ErrMax) err_count <= err_count + (ADDR_W + 1)'(1);
            if (err_count == '0)     fail_n    <= sq_n;
            state_q <= StNext;
          end
`endif
        end
        StCheck: begin
          if (!ok) begin
            if (err_count != ErrMax) err_count <= err_count + (ADDR_W + 1)'(1);
            if (err_count == '0)     fail_n    <= sq_n;
          end
          state_q <= StNext;
        end
        StNext: begin
          if (mem_addr == LastIdx) begin
            state_q <= StDone;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            state_q  <= StRead;
          end
        end
        StDone: begin
          pass    <= (err_count == '0);
          fail    <= (err_count != '0);
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_sweep_driver.sv
// Directed bench for sqrt_sweep_driver with a memory model and a square-root responder.
module tb_sqrt_sweep_driver;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go  = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'd0;
  logic              sq_start;
  logic [7:0]        sq_n;
  logic              sq_done = 1'b1;   // stale done left over from a previous user
  logic [3:0]        sq_root = 4'd9;   // stale, wrong root
  logic              busy;
  logic              pass;
  logic              fail;
  logic [ADDR_W:0]   err_count;
  logic [7:0]        fail_n;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16];
  logic [3:0] root_tab [4];
  int         hang_k   = -1;
  int         resp_lat = 0;

  logic       clr_mon = 1'b0;
  int         start_cnt = 0;
  int         unstable = 0;
  int         op_k = 0;
  int         wcnt = 0;
  logic       in_op = 1'b0;
  logic       pend = 1'b0;
  logic       start_d = 1'b0;
  logic [7:0] cur_n = 8'd0;
  logic [7:0] started_n [8];

  sqrt_sweep_driver #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .sq_start  (sq_start),
    .sq_n      (sq_n),
    .sq_done   (sq_done),
    .sq_root   (sq_root),
    .busy      (busy),
    .pass      (pass),
    .fail      (fail),
    .err_count (err_count),
    .fail_n    (fail_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  // Responder: clears done one cycle after start, answers resp_lat cycles later.
  always @(posedge clk) begin
    if (clr_mon) begin
      start_cnt <= 0;
      unstable  <= 0;
      in_op     <= 1'b0;
    end else if (sq_start) begin
      if (start_cnt < 8) started_n[start_cnt] <= sq_n;
      cur_n     <= sq_n;
      op_k      <= start_cnt;
      start_cnt <= start_cnt + 1;
      in_op     <= 1'b1;
    end else if (in_op && sq_n !== cur_n) begin
      unstable <= unstable + 1;
    end
    start_d <= sq_start;
    if (start_d) begin
      sq_done <= 1'b0;
      pend    <= 1'b1;
      wcnt    <= resp_lat;
    end else if (pend) begin
      if (wcnt == 0) begin
        pend  <= 1'b0;
        in_op <= 1'b0;
        if (op_k != hang_k) begin
          sq_done <= 1'b1;
          sq_root <= root_tab[op_k[1:0]];
        end
      end else begin
        wcnt <= wcnt - 1;
      end
    end
  end

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk) clr_mon = 1'b1;
    @(negedge clk) clr_mon = 1'b0;
  endtask

  task automatic set_golden();
    root_tab[0] = 4'd0;
    root_tab[1] = 4'd3;
    root_tab[2] = 4'd4;
    root_tab[3] = 4'd15;
    hang_k      = -1;
    resp_lat    = 0;
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s sweep_end: busy still %b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, sq_start, pass, fail} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/start/pass/fail=%b want 0000", {busy, sq_start, pass, fail});
    end
    checks++;
    if (err_count !== '0 || fail_n !== 8'd0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_values: err=%0d fail_n=%0d addr=%0d want 0 0 0",
               err_count, fail_n, mem_addr);
    end
    rst = 1'b0;
    set_golden();
    clear_mon();
    pulse_go();
    while (start_cnt < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (start_cnt < 1) begin
      errors++;
      $display("FAIL reset_first_start: starts=%0d want 1", start_cnt);
    end
    @(negedge clk);  // now inside WAIT
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, sq_start, pass, fail} !== 4'b0000 || err_count !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: busy/start/pass/fail=%b err=%0d want 0000 0",
               {busy, sq_start, pass, fail}, err_count);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (start_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume: starts=%0d busy=%b want 1 0", start_cnt, busy);
    end
  endtask

  task automatic test_golden();
    set_golden();
    clear_mon();
    pulse_go();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL golden_busy: busy=%b want 1", busy);
    end
    wait_sweep("golden");
    checks++;
    if (start_cnt !== 4) begin
      errors++;
      $display("FAIL golden_starts: starts=%0d want 4", start_cnt);
    end
    checks++;
    if ({pass, fail} !== 2'b10 || err_count !== '0 || fail_n !== 8'd0) begin
      errors++;
      $display("FAIL golden_result: pass=%b fail=%b err=%0d fail_n=%0d want 1 0 0 0",
               pass, fail, err_count, fail_n);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (started_n[k] !== mem[k]) begin
        errors++;
        $display("FAIL golden_operand%0d: sq_n=%0d want %0d", k, started_n[k], mem[k]);
      end
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL golden_sq_n_stable: changes=%0d want 0", unstable);
    end
  endtask

  task automatic test_bad_result();
    set_golden();
    root_tab[2] = 4'd5;
    clear_mon();
    pulse_go();
    wait_sweep("bad");
    checks++;
    if ({pass, fail} !== 2'b01 || err_count !== 5'd1 || fail_n !== 8'd16) begin
      errors++;
      $display("FAIL bad_result: pass=%b fail=%b err=%0d fail_n=%0d want 0 1 1 16",
               pass, fail, err_count, fail_n);
    end
    checks++;
    if (start_cnt !== 4) begin
      errors++;
      $display("FAIL bad_starts: starts=%0d want 4", start_cnt);
    end
  endtask

  task automatic test_boundary();
    set_golden();
    root_tab[3] = 4'd14;
    clear_mon();
    pulse_go();
    checks++;
    if ({pass, fail} !== 2'b00 || err_count !== '0 || fail_n !== 8'd0) begin
      errors++;
      $display("FAIL go_clears: pass=%b fail=%b err=%0d fail_n=%0d want 0 0 0 0",
               pass, fail, err_count, fail_n);
    end
    wait_sweep("boundary");
    checks++;
    if (fail !== 1'b1 || err_count !== 5'd1 || fail_n !== 8'd255) begin
      errors++;
      $display("FAIL boundary_r14: fail=%b err=%0d fail_n=%0d want 1 1 255",
               fail, err_count, fail_n);
    end
    // Two failures with a slow responder: fail_n keeps the first one.
    set_golden();
    root_tab[1] = 4'd4;
    root_tab[3] = 4'd14;
    resp_lat    = 3;
    clear_mon();
    pulse_go();
    wait_sweep("two_err");
    checks++;
    if (fail !== 1'b1 || err_count !== 5'd2 || fail_n !== 8'd15) begin
      errors++;
      $display("FAIL two_errors: fail=%b err=%0d fail_n=%0d want 1 2 15",
               fail, err_count, fail_n);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL slow_sq_n_stable: changes=%0d want 0", unstable);
    end
  endtask

  task automatic test_go_while_busy();
    int n = 0;
    set_golden();
    clear_mon();
    pulse_go();
    while (start_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    pulse_go();
    wait_sweep("go_busy");
    checks++;
    if (start_cnt !== 4 || {pass, fail} !== 2'b10) begin
      errors++;
      $display("FAIL go_while_busy: starts=%0d pass=%b fail=%b want 4 1 0",
               start_cnt, pass, fail);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (start_cnt !== 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL go_dropped: starts=%0d busy=%b want 4 0", start_cnt, busy);
    end
  endtask

  task automatic test_go_with_rst();
    clear_mon();
    @(negedge clk);
    rst = 1'b1;
    go  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    go  = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || start_cnt !== 0) begin
      errors++;
      $display("FAIL go_with_rst: busy=%b starts=%0d want 0 0", busy, start_cnt);
    end
  endtask

`ifdef SQRT_TIMEOUT_EN
  task automatic test_timeout();
    set_golden();
    hang_k = 1;
    clear_mon();
    pulse_go();
    wait_sweep("timeout");
    checks++;
    if (fail !== 1'b1 || err_count !== 5'd1 || fail_n !== 8'd15 || start_cnt !== 4) begin
      errors++;
      $display("FAIL timeout: fail=%b err=%0d fail_n=%0d starts=%0d want 1 1 15 4",
               fail, err_count, fail_n, start_cnt);
    end
    hang_k = -1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    mem[0] = 8'd0;
    mem[1] = 8'd15;
    mem[2] = 8'd16;
    mem[3] = 8'd255;
    for (int i = 0; i < 8; i++) started_n[i] = 8'd0;
    test_reset();
    test_golden();
    test_bad_result();
    test_boundary();
    test_go_while_busy();
    test_go_with_rst();
`ifdef SQRT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
